// File: rtl/timer_clk_pkg.sv
// rtl/timer_clk_pkg.sv - shared clock-select encodings and prescaler widths
package timer_clk_pkg;

    typedef enum logic [2:0] {
        CS_STOP     = 3'b000,
        CS_DIV1     = 3'b001,
        CS_DIV8     = 3'b010,
        CS_DIV64    = 3'b011,
        CS_DIV256   = 3'b100,
        CS_DIV1024  = 3'b101,
        CS_EXT_FALL = 3'b110,
        CS_EXT_RISE = 3'b111
    } cs_e;

    localparam int PSC_WIDTH   = 10;
    localparam int TAP8_W      = 3;
    localparam int TAP64_W     = 6;
    localparam int TAP256_W    = 8;
    localparam int TAP1024_W   = 10;

endpackage

// File: rtl/tn_edge_detect.sv
// rtl/tn_edge_detect.sv - Tn pin synchroniser with masked falling/rising edge pulses
module tn_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic nrst,
    input  logic pin,
    input  logic mask,
    output logic fall,
    output logic rise
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   dly;
    logic                   sync;

    assign sync = chain[SYNC_STAGES-1];

    // Synchroniser chain plus one delay flop; runs every cycle so no edge is stored across cs changes
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            chain <= '0;
            dly   <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], pin};
            dly   <= sync;
        end
    end

    // Edge pulses are suppressed while the startup mask is active
    always_comb begin
        fall = dly & ~sync & ~mask;
        rise = ~dly & sync & ~mask;
    end

endmodule

// File: rtl/timer_clk_sel_n.sv
// rtl/timer_clk_sel_n.sv - shared prescaler and per-channel clock-enable selection
module timer_clk_sel_n
    import timer_clk_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              psrsync,
    input  logic              tsm,
    input  logic [N_CH-1:0]   t_pin,
    input  logic [3*N_CH-1:0] cs,
    output logic [N_CH-1:0]   clk_en,
    output logic              psrsync_clr,
    output logic              psc_halted
);

    localparam int             ST_W   = $clog2(SYNC_STAGES + 2);
    localparam logic [ST_W-1:0] ST_MAX = ST_W'(SYNC_STAGES + 1);

    logic [PSC_WIDTH-1:0] psc;
    logic [ST_W-1:0]      st_cnt;
    logic                 st_mask;
    logic                 en8, en64, en256, en1024;
    logic [N_CH-1:0]      fall, rise;

    // Prescaler: free-running, cleared by PSRSYNC and held at zero while TSM keeps it asserted
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            psc         <= '0;
            psrsync_clr <= 1'b0;
            psc_halted  <= 1'b0;
        end else begin
            psc         <= psrsync ? '0 : psc + PSC_WIDTH'(1);
            psrsync_clr <= psrsync & ~tsm;
            psc_halted  <= psrsync & tsm;
        end
    end

    // Startup counter: masks edge detection until the sync chains hold post-reset pin values
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            st_cnt <= '0;
        end else if (st_cnt != ST_MAX) begin
            st_cnt <= st_cnt + ST_W'(1);
        end
    end

    assign st_mask = (st_cnt != ST_MAX);

    // Tap pulses decoded from the low bits of the prescaler
    always_comb begin
        en8    = &psc[TAP8_W-1:0];
        en64   = &psc[TAP64_W-1:0];
        en256  = &psc[TAP256_W-1:0];
        en1024 = &psc[TAP1024_W-1:0];
    end

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_tn
            tn_edge_detect #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_tn (
                .clk  (clk),
                .nrst (nrst),
                .pin  (t_pin[g]),
                .mask (st_mask),
                .fall (fall[g]),
                .rise (rise[g])
            );
        end
    endgenerate

    // Per-channel source select; a TSM hold silences every channel
    always_comb begin
        clk_en = '0;
        for (int i = 0; i < N_CH; i++) begin
            case (cs[3*i +: 3])
                CS_STOP:     clk_en[i] = 1'b0;
                CS_DIV1:     clk_en[i] = 1'b1;
                CS_DIV8:     clk_en[i] = en8;
                CS_DIV64:    clk_en[i] = en64;
                CS_DIV256:   clk_en[i] = en256;
                CS_DIV1024:  clk_en[i] = en1024;
                CS_EXT_FALL: clk_en[i] = fall[i];
                CS_EXT_RISE: clk_en[i] = rise[i];
                default:     clk_en[i] = 1'b0;
            endcase
            if (psc_halted) begin
                clk_en[i] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_timer_clk_sel_n.sv
// tb/tb_timer_clk_sel_n.sv - directed self-checking bench for timer_clk_sel_n
module tb_timer_clk_sel_n;

    logic        clk = 1'b0;
    logic        nrst;
    logic        psrsync;
    logic        tsm;
    logic [3:0]  t_pin;
    logic [11:0] cs;
    logic [3:0]  clk_en;
    logic        psrsync_clr;
    logic        psc_halted;

    int tests = 0;
    int fails = 0;
    int n1024 = 0;

    timer_clk_sel_n #(.N_CH(4), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .psrsync     (psrsync),
        .tsm         (tsm),
        .t_pin       (t_pin),
        .cs          (cs),
        .clk_en      (clk_en),
        .psrsync_clr (psrsync_clr),
        .psc_halted  (psc_halted)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Compares {psc_halted, psrsync_clr, clk_en} against an expected vector
    task automatic chk(input string tag, input logic [5:0] exp);
        logic [5:0] got;
        got = {psc_halted, psrsync_clr, clk_en};
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s halted_clr_en=%b expected=%b", tag, got, exp);
        end
    endtask

    initial begin
        nrst    = 1'b0;
        psrsync = 1'b0;
        tsm     = 1'b0;
        t_pin   = 4'b1000;
        cs      = {3'b111, 3'b000, 3'b101, 3'b010};
        tick(2);
        chk("reset_state", 6'b00_0000);
        cs[2:0] = 3'b001;
        #1;
        chk("reset_div1", 6'b00_0001);
        cs[2:0] = 3'b010;
        #1;
        chk("reset_div8", 6'b00_0000);

        // Prescaler taps over two full periods; ch3 pin held high stays masked
        nrst = 1'b1;
        for (int c = 1; c <= 2048; c++) begin
            tick(1);
            if (clk_en[1]) n1024++;
            chk("taps", {2'b00, 1'b0, 1'b0, (c % 1024) == 1023, (c % 8) == 7});
        end
        tests++;
        assert (n1024 == 2) else begin
            fails++;
            $error("FAIL div1024_count got=%0d expected=2", n1024);
        end

        // Startup mask released: a later 0->1 on t_pin[3] gives one pulse
        cs[5:0] = 6'b000_000;
        t_pin[3] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            chk("ch3_fall_ignored", 6'b00_0000);
        end
        t_pin[3] = 1'b1;
        tick(1); chk("ch3_rise_e1", 6'b00_0000);
        tick(1); chk("ch3_rise_e2", 6'b00_1000);
        tick(1); chk("ch3_rise_e3", 6'b00_0000);

        // External falling / rising edge latency on channel 2
        cs[8:6] = 3'b110;
        t_pin[2] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            chk("ch2_rise_on_fallmode", 6'b00_0000);
        end
        t_pin[2] = 1'b0;
        tick(1); chk("ch2_fall_e20", 6'b00_0000);
        tick(1); chk("ch2_fall_e21", 6'b00_0100);
        tick(1); chk("ch2_fall_e22", 6'b00_0000);
        cs[8:6] = 3'b111;
        t_pin[2] = 1'b1;
        tick(1); chk("ch2_rise_e20", 6'b00_0000);
        tick(1); chk("ch2_rise_e21", 6'b00_0100);
        tick(1); chk("ch2_rise_e22", 6'b00_0000);
        t_pin[2] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            chk("ch2_fall_on_risemode", 6'b00_0000);
        end
        cs[8:6] = 3'b000;

        // Prescaler reset without TSM
        cs[2:0] = 3'b011;
        psrsync = 1'b1;
        tick(1); chk("psr_first_clr", 6'b01_0000);
        psrsync = 1'b0;
        for (int k = 2; k <= 40; k++) begin
            tick(1);
            chk("psr_count_to_40", 6'b00_0000);
        end
        psrsync = 1'b1;
        tick(1); chk("psr_at_40_clr", 6'b01_0000);
        psrsync = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            tick(1);
            chk("psr_en64", {2'b00, 3'b000, k == 63});
        end

        // TSM hold then release
        cs = {3'b000, 3'b000, 3'b010, 3'b001};
        tsm = 1'b1;
        psrsync = 1'b1;
        for (int k = 0; k < 100; k++) begin
            tick(1);
            chk("tsm_hold", 6'b10_0000);
        end
        tsm = 1'b0;
        tick(1); chk("tsm_release", 6'b01_0001);
        psrsync = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            chk("tsm_resume", {2'b00, 2'b00, (k % 8) == 7, 1'b1});
        end

        // Asynchronous reset mid-count
        cs = {3'b111, 3'b000, 3'b000, 3'b010};
        tick(484);
        #2;
        nrst = 1'b0;
        #1;
        chk("async_reset", 6'b00_0000);
        cs[5:3] = 3'b001;
        #1;
        chk("async_reset_div1", 6'b00_0010);
        tick(2);
        cs[5:3] = 3'b000;
        nrst = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            chk("restart", {2'b00, 3'b000, (k % 8) == 7});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
